pc_predict_ras: RTL and testbench

Parametrised fetch-PC register and next-PC predictor for the pipelined Y86-64 core. It replaces the single-cycle combinational PC update with a registered predicted PC. It handles jXX with static prediction, call/ret with a return-address stack (RAS), and takes late redirects from the memory stage and the writeback stage. It sits at the front of fetch, feeds the instruction memory address, and receives correction inputs from downstream pipeline registers.

---
 rtl/pc_predict_ras_if.sv | 42 ++++
 rtl/pc_predict_ras.sv | 112 +++++++++++
 tb/tb_pc_predict_ras.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pc_predict_ras_if.sv
// pc_predict_ras_if: fetch-side bundle for the PC predictor.
//   master: pipeline side, drives fetch info and late redirects, reads PC/predictions.
//   slave : predictor side (pc_predict_ras).
// Signals:
//   f_stall, f_icode, f_valC, f_valP       fetched instruction info
//   m_redirect, m_target                   memory-stage mispredict fix
//   w_ret, w_valM, w_pred                  writeback ret check
//   f_pc, f_pred_ret, f_jxx_taken          fetch address and predictions
//   ras_count, ras_underflow               RAS status
interface pc_predict_ras_if #(
  parameter int WIDTH     = 64,
  parameter int RAS_DEPTH = 8
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic             f_stall;
  logic [3:0]       f_icode;
  logic [WIDTH-1:0] f_valC;
  logic [WIDTH-1:0] f_valP;
  logic             m_redirect;
  logic [WIDTH-1:0] m_target;
  logic             w_ret;
  logic [WIDTH-1:0] w_valM;
  logic [WIDTH-1:0] w_pred;
  logic [WIDTH-1:0] f_pc;
  logic [WIDTH-1:0] f_pred_ret;
  logic             f_jxx_taken;
  logic [CW-1:0]    ras_count;
  logic             ras_underflow;

  modport master (
    output f_stall, f_icode, f_valC, f_valP, m_redirect, m_target,
           w_ret, w_valM, w_pred,
    input  f_pc, f_pred_ret, f_jxx_taken, ras_count, ras_underflow
  );

  modport slave (
    input  f_stall, f_icode, f_valC, f_valP, m_redirect, m_target,
           w_ret, w_valM, w_pred,
    output f_pc, f_pred_ret, f_jxx_taken, ras_count, ras_underflow
  );
endinterface

// File: rtl/pc_predict_ras.sv
// pc_predict_ras: registered fetch PC with next-PC prediction for Y86-64.
//   jXX: static prediction (always taken, or BTFN when PREDICT_MODE=1).
//   call/ret: return-address stack, oldest entry overwritten when full.
//   Late redirects: writeback ret mismatch beats memory-stage mispredict.
// Ports:
//   clk, rst  clock, async active-high reset
//   bus       pc_predict_ras_if.slave (fetch info in, f_pc/predictions out)
module pc_predict_ras #(
  parameter int               WIDTH        = 64,
  parameter int               RAS_DEPTH    = 8,
  parameter logic [WIDTH-1:0] RESET_PC     = '0,
  parameter int               PREDICT_MODE = 0
) (
  input  logic clk,
  input  logic rst,
  pc_predict_ras_if.slave bus
);
  localparam int            PW   = $clog2(RAS_DEPTH);
  localparam logic [PW:0]   FULL = (PW+1)'(RAS_DEPTH);

  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;

  logic [WIDTH-1:0]                pred_pc_q, pred_pc_d;
  logic [RAS_DEPTH-1:0][WIDTH-1:0] ras_q, ras_d;
  logic [PW-1:0]                   tp_q, tp_d;
  logic [PW:0]                     cnt_q, cnt_d;

  logic             w_fix;
  logic [WIDTH-1:0] f_pc;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] pred_ret;
  logic             jxx_taken;
  logic             underflow;
  logic             do_push, do_pop;
  logic [PW-1:0]    tp_inc;

  // A ret whose prediction turned out right needs no fix.
  assign w_fix = bus.w_ret && (bus.w_valM != bus.w_pred);
  // Older instruction wins: writeback fix over memory redirect.
  assign f_pc  = w_fix ? bus.w_valM : (bus.m_redirect ? bus.m_target : pred_pc_q);
  assign tp_inc = tp_q + 1'b1;

  always_comb begin
    next_pc   = bus.f_valP;
    pred_ret  = bus.f_valP;
    jxx_taken = 1'b0;
    underflow = 1'b0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    case (bus.f_icode)
      I_JXX: begin
        jxx_taken = (PREDICT_MODE == 0) ? 1'b1 : (bus.f_valC < bus.f_valP);
        next_pc   = jxx_taken ? bus.f_valC : bus.f_valP;
      end
      I_CALL: begin
        next_pc = bus.f_valC;
        do_push = 1'b1;
      end
      I_RET: begin
        if (cnt_q != '0) begin
          next_pc = ras_q[tp_q];
          do_pop  = 1'b1;
        end else begin
          underflow = 1'b1;
        end
        pred_ret = next_pc;
      end
      default: ;
    endcase
  end

  always_comb begin
    pred_pc_d = f_pc;
    ras_d     = ras_q;
    tp_d      = tp_q;
    cnt_d     = cnt_q;
    if (!bus.f_stall) begin
      pred_pc_d = next_pc;
      if (do_push) begin
        // When full the write lands on the oldest slot; count saturates.
        ras_d[tp_inc] = bus.f_valP;
        tp_d          = tp_inc;
        if (cnt_q != FULL) cnt_d = cnt_q + 1'b1;
      end else if (do_pop) begin
        tp_d  = tp_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_pc_q <= RESET_PC;
      ras_q     <= '0;
      tp_q      <= '0;
      cnt_q     <= '0;
    end else begin
      pred_pc_q <= pred_pc_d;
      ras_q     <= ras_d;
      tp_q      <= tp_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.f_pc          = f_pc;
  assign bus.f_pred_ret    = pred_ret;
  assign bus.f_jxx_taken   = jxx_taken;
  assign bus.ras_count     = cnt_q;
  assign bus.ras_underflow = underflow;
endmodule

// File: tb/tb_pc_predict_ras.sv
module tb_pc_predict_ras;
  localparam int W = 64;
  localparam int D = 4;
  localparam logic [W-1:0] RPC = 64'h100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         f_stall, m_redirect, w_ret;
  logic [3:0]   f_icode;
  logic [W-1:0] f_valC, f_valP, m_target, w_valM, w_pred;

  int n_cmp = 0;
  int n_bad = 0;

  pc_predict_ras_if #(.WIDTH(W), .RAS_DEPTH(D)) b0 ();
  pc_predict_ras_if #(.WIDTH(W), .RAS_DEPTH(D)) b1 ();

  // Both predictors see the same stimulus; only jXX policy differs.
  assign b0.f_stall = f_stall;    assign b1.f_stall = f_stall;
  assign b0.f_icode = f_icode;    assign b1.f_icode = f_icode;
  assign b0.f_valC = f_valC;      assign b1.f_valC = f_valC;
  assign b0.f_valP = f_valP;      assign b1.f_valP = f_valP;
  assign b0.m_redirect = m_redirect; assign b1.m_redirect = m_redirect;
  assign b0.m_target = m_target;  assign b1.m_target = m_target;
  assign b0.w_ret = w_ret;        assign b1.w_ret = w_ret;
  assign b0.w_valM = w_valM;      assign b1.w_valM = w_valM;
  assign b0.w_pred = w_pred;      assign b1.w_pred = w_pred;

  pc_predict_ras #(.WIDTH(W), .RAS_DEPTH(D), .RESET_PC(RPC), .PREDICT_MODE(0))
    dut0 (.clk(clk), .rst(rst), .bus(b0));
  pc_predict_ras #(.WIDTH(W), .RAS_DEPTH(D), .RESET_PC(RPC), .PREDICT_MODE(1))
    dut1 (.clk(clk), .rst(rst), .bus(b1));

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [W-1:0] c, input logic [W-1:0] p);
    f_icode = ic; f_valC = c; f_valP = p;
  endtask

  task automatic test_reset();
    rst = 1'b1; f_stall = 0; m_redirect = 0; w_ret = 0;
    m_target = '0; w_valM = '0; w_pred = '0;
    fetch(4'h1, 64'h0, 64'h101);
    tick(); tick();
    #1;
    n_cmp++; if (b0.f_pc !== 64'h100) begin n_bad++; $display("FAIL rst_pc: got %h want %h", b0.f_pc, 64'h100); end
    n_cmp++; if (b0.ras_count !== 3'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", b0.ras_count); end
    n_cmp++; if (b0.f_jxx_taken !== 1'b0 || b0.ras_underflow !== 1'b0) begin n_bad++; $display("FAIL rst_flags: got %b%b want 00", b0.f_jxx_taken, b0.ras_underflow); end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (b0.f_pc !== 64'h100) begin n_bad++; $display("FAIL cyc0_pc: got %h want %h", b0.f_pc, 64'h100); end
    tick(); #1;
    n_cmp++; if (b0.f_pc !== 64'h101) begin n_bad++; $display("FAIL cyc1_pc: got %h want %h", b0.f_pc, 64'h101); end
    n_cmp++; if (b0.ras_count !== 3'd0) begin n_bad++; $display("FAIL cyc1_cnt: got %0d want 0", b0.ras_count); end
  endtask

  task automatic test_jxx();
    // Backward branch: taken in both modes.
    tick();
    m_redirect = 1; m_target = 64'h200; fetch(4'h7, 64'h180, 64'h209);
    #1;
    n_cmp++; if (b0.f_pc !== 64'h200 || b1.f_pc !== 64'h200) begin n_bad++; $display("FAIL jxx_redir_pc: got %h/%h want 200", b0.f_pc, b1.f_pc); end
    n_cmp++; if (b0.f_jxx_taken !== 1'b1 || b1.f_jxx_taken !== 1'b1) begin n_bad++; $display("FAIL jxx_back_taken: got %b/%b want 1/1", b0.f_jxx_taken, b1.f_jxx_taken); end
    tick();
    m_redirect = 0; fetch(4'h1, 64'h0, 64'h1000);
    #1;
    n_cmp++; if (b0.f_pc !== 64'h180 || b1.f_pc !== 64'h180) begin n_bad++; $display("FAIL jxx_back_next: got %h/%h want 180", b0.f_pc, b1.f_pc); end
    // Forward branch: mode 0 taken, BTFN not taken.
    m_redirect = 1; m_target = 64'h200; fetch(4'h7, 64'h300, 64'h209);
    #1;
    n_cmp++; if (b0.f_jxx_taken !== 1'b1 || b1.f_jxx_taken !== 1'b0) begin n_bad++; $display("FAIL jxx_fwd_taken: got %b/%b want 1/0", b0.f_jxx_taken, b1.f_jxx_taken); end
    tick();
    m_redirect = 0; fetch(4'h1, 64'h0, 64'h1000);
    #1;
    n_cmp++; if (b0.f_pc !== 64'h300) begin n_bad++; $display("FAIL jxx_fwd_m0: got %h want 300", b0.f_pc); end
    n_cmp++; if (b1.f_pc !== 64'h209) begin n_bad++; $display("FAIL jxx_fwd_m1: got %h want 209", b1.f_pc); end
  endtask

  task automatic test_call_ret();
    m_redirect = 1; m_target = 64'h200; fetch(4'h8, 64'h400, 64'h20A);
    #1;
    n_cmp++; if (b0.ras_count !== 3'd0) begin n_bad++; $display("FAIL call_cnt0: got %0d want 0", b0.ras_count); end
    tick();
    m_redirect = 0; fetch(4'h9, 64'h0, 64'h401);
    #1;
    n_cmp++; if (b0.f_pc !== 64'h400) begin n_bad++; $display("FAIL call_target: got %h want 400", b0.f_pc); end
    n_cmp++; if (b0.ras_count !== 3'd1) begin n_bad++; $display("FAIL call_cnt1: got %0d want 1", b0.ras_count); end
    n_cmp++; if (b0.f_pred_ret !== 64'h20A || b0.ras_underflow !== 1'b0) begin n_bad++; $display("FAIL ret_pred: got %h/%b want 20a/0", b0.f_pred_ret, b0.ras_underflow); end
    tick();
    fetch(4'h1, 64'h0, 64'h20B);
    #1;
    n_cmp++; if (b0.f_pc !== 64'h20A || b1.f_pc !== 64'h20A) begin n_bad++; $display("FAIL ret_next: got %h/%h want 20a", b0.f_pc, b1.f_pc); end
    n_cmp++; if (b0.ras_count !== 3'd0) begin n_bad++; $display("FAIL ret_cnt: got %0d want 0", b0.ras_count); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] a;
    for (int i = 1; i <= 5; i++) begin
      tick();
      a = 64'h1000 + 64'(i) * 64'h10;
      fetch(4'h8, 64'h800, a);
    end
    tick();
    fetch(4'h1, 64'h0, 64'h900);
    #1;
    n_cmp++; if (b0.ras_count !== 3'd4) begin n_bad++; $display("FAIL ovf_cnt: got %0d want 4", b0.ras_count); end
    for (int i = 0; i < 5; i++) begin
      tick();
      fetch(4'h9, 64'h0, 64'h900 + 64'(i));
      #1;
      if (i < 4) begin
        a = 64'h1000 + 64'(5 - i) * 64'h10;  // A5, A4, A3, A2
        n_cmp++; if (b0.f_pred_ret !== a || b0.ras_underflow !== 1'b0) begin n_bad++; $display("FAIL ovf_pop%0d: got %h/%b want %h/0", i, b0.f_pred_ret, b0.ras_underflow, a); end
      end else begin
        n_cmp++; if (b0.ras_underflow !== 1'b1 || b0.f_pred_ret !== 64'h904) begin n_bad++; $display("FAIL unf_pop: got %h/%b want 904/1", b0.f_pred_ret, b0.ras_underflow); end
      end
    end
    tick();
    fetch(4'h1, 64'h0, 64'h905);
    #1;
    n_cmp++; if (b0.f_pc !== 64'h904 || b0.ras_count !== 3'd0) begin n_bad++; $display("FAIL unf_next: got %h/%0d want 904/0", b0.f_pc, b0.ras_count); end
  endtask

  task automatic test_redirect_priority();
    m_redirect = 1; m_target = 64'h500;
    w_ret = 1; w_valM = 64'h600; w_pred = 64'h610;
    fetch(4'h1, 64'h0, 64'h777);
    #1;
    n_cmp++; if (b0.f_pc !== 64'h600) begin n_bad++; $display("FAIL prio_wfix: got %h want 600", b0.f_pc); end
    w_valM = 64'h610;
    #1;
    n_cmp++; if (b0.f_pc !== 64'h500) begin n_bad++; $display("FAIL prio_nofix: got %h want 500", b0.f_pc); end
    tick();
    m_redirect = 0; w_ret = 0;
    #1;
    n_cmp++; if (b0.f_pc !== 64'h777 || b1.f_pc !== 64'h777) begin n_bad++; $display("FAIL prio_next: got %h/%h want 777", b0.f_pc, b1.f_pc); end
  endtask

  task automatic test_stall_reset();
    f_stall = 1; fetch(4'h8, 64'h999, 64'h123);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      n_cmp++; if (b0.f_pc !== 64'h777 || b0.ras_count !== 3'd0) begin n_bad++; $display("FAIL stall_hold%0d: got %h/%0d want 777/0", i, b0.f_pc, b0.ras_count); end
    end
    m_redirect = 1; m_target = 64'hABC;
    tick();
    m_redirect = 0;
    #1;
    n_cmp++; if (b0.f_pc !== 64'hABC || b0.ras_count !== 3'd0) begin n_bad++; $display("FAIL stall_redir: got %h/%0d want abc/0", b0.f_pc, b0.ras_count); end
    f_stall = 0;
    tick();
    f_stall = 1; fetch(4'h1, 64'h0, 64'h55);
    #1;
    n_cmp++; if (b0.f_pc !== 64'h999 || b0.ras_count !== 3'd1) begin n_bad++; $display("FAIL unstall_call: got %h/%0d want 999/1", b0.f_pc, b0.ras_count); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (b0.f_pc !== RPC || b0.ras_count !== 3'd0) begin n_bad++; $display("FAIL async_rst: got %h/%0d want 100/0", b0.f_pc, b0.ras_count); end
    tick();
    rst = 1'b0; f_stall = 0;
    #1;
    n_cmp++; if (b1.f_pc !== RPC) begin n_bad++; $display("FAIL rst_release: got %h want 100", b1.f_pc); end
  endtask

  initial begin
    test_reset();
    test_jxx();
    test_call_ret();
    test_overflow();
    test_redirect_priority();
    test_stall_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
